// File: rtl/gpio_filt_pkg.sv
// Shared defaults and types for the GPIO input conditioning stage.
package gpio_filt_pkg;

    localparam int GPIO_FILT_NBITS = 8;
    localparam int GPIO_FILT_SYNC  = 2;
    localparam int GPIO_FILT_CNT_W = 8;

    // Same width as the controller's gpioi_din bus.
    typedef logic [31:0] gpio_vec_t;

    // Classify a debounced-level transition as {rise, fall}.
    function automatic logic [1:0] edge_pair(input logic cur_lvl, input logic nxt_lvl);
        logic [1:0] res;
        res = {(~cur_lvl & nxt_lvl), (cur_lvl & ~nxt_lvl)};
        return res;
    endfunction

endpackage

// File: rtl/gpio_filt_bit.sv
// One conditioned GPIO line: synchroniser, debounce counter, level/edge
// registers and the sticky pending flag.
module gpio_filt_bit
    import gpio_filt_pkg::*;
#(
    parameter int SYNC_STAGES = GPIO_FILT_SYNC,
    parameter int CNT_W       = GPIO_FILT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             pad,
    input  logic             evt_clr,
    output logic             din,
    output logic             rise,
    output logic             fall,
    output logic             pend,
    output logic             pend_next
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   din_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   pend_r;

    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_next_s;
    logic                   din_next_s;
    logic                   rise_next_s;
    logic                   fall_next_s;
    logic                   pend_next_s;

    // Next-state for the debounce counter, level, edges and pending flag.
    always_comb begin
        sync_s      = sync_r[SYNC_STAGES-1];
        din_next_s  = din_r;
        cnt_next_s  = cnt_r;
        if (!cfg_en) begin
            // Bypass: follow the synchronised level, keep counts cleared so
            // re-enabling starts a fresh qualification.
            din_next_s = sync_s;
            cnt_next_s = '0;
        end else if (sync_s == din_r) begin
            cnt_next_s = '0;
        end else if (cnt_r >= cfg_limit) begin
            // >= (not ==) so a limit lowered below the running count takes
            // effect on the next disagreeing cycle instead of wrapping.
            din_next_s = sync_s;
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
        {rise_next_s, fall_next_s} = edge_pair(din_r, din_next_s);
        // A new event wins over a simultaneous clear.
        pend_next_s = (pend_r & ~evt_clr) | rise_next_s | fall_next_s;
    end

    // State registers; reset discards any count in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            cnt_r  <= '0;
            din_r  <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pad};
            cnt_r  <= cnt_next_s;
            din_r  <= din_next_s;
            rise_r <= rise_next_s;
            fall_r <= fall_next_s;
            pend_r <= pend_next_s;
        end
    end

    assign din       = din_r;
    assign rise      = rise_r;
    assign fall      = fall_r;
    assign pend      = pend_r;
    assign pend_next = pend_next_s;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: per-line synchronise + debounce, edge pulses,
// sticky pending flags and a registered interrupt summary.
module gpio_in_filter
    import gpio_filt_pkg::*;
#(
    parameter int NBITS       = GPIO_FILT_NBITS,
    parameter int SYNC_STAGES = GPIO_FILT_SYNC,
    parameter int CNT_W       = GPIO_FILT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic [NBITS-1:0] pad_i,
    input  logic [NBITS-1:0] evt_clr_i,
    output logic [NBITS-1:0] din_o,
    output logic [NBITS-1:0] rise_o,
    output logic [NBITS-1:0] fall_o,
    output logic [NBITS-1:0] pend_o,
    output logic             irq_o
);

    logic [NBITS-1:0] pend_next_s;
    logic             irq_r;

    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        gpio_filt_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_bit (
            .clk       (clk),
            .rst       (rst),
            .cfg_en    (cfg_en),
            .cfg_limit (cfg_limit),
            .pad       (pad_i[i]),
            .evt_clr   (evt_clr_i[i]),
            .din       (din_o[i]),
            .rise      (rise_o[i]),
            .fall      (fall_o[i]),
            .pend      (pend_o[i]),
            .pend_next (pend_next_s[i])
        );
    end

    // Interrupt built from next-state pend so it lines up with pend_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |pend_next_s;
        end
    end

    assign irq_o = irq_r;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Self-checking bench for gpio_in_filter: table of directed vectors plus
// hand-written multi-cycle sequences, checked through a cycle-stamped
// scoreboard queue.
module tb_gpio_in_filter;

    logic       clk;
    logic       rst;
    logic       cfg_en;
    logic [7:0] cfg_limit;
    logic [7:0] pad_i;
    logic [7:0] evt_clr_i;
    logic [7:0] din_o;
    logic [7:0] rise_o;
    logic [7:0] fall_o;
    logic [7:0] pend_o;
    logic       irq_o;

    gpio_in_filter #(.NBITS(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_en    (cfg_en),
        .cfg_limit (cfg_limit),
        .pad_i     (pad_i),
        .evt_clr_i (evt_clr_i),
        .din_o     (din_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .pend_o    (pend_o),
        .irq_o     (irq_o)
    );

    typedef struct {
        logic       en;
        logic [7:0] lim;
        logic [7:0] pad;
        logic [7:0] clr;
        int         w;
        logic       every;
        logic [7:0] din;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] pend;
        logic       irq;
    } vec_t;

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] din;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] pend;
        logic       irq;
    } exp_t;

    localparam int NV = 35;
    vec_t vecs [NV];
    exp_t sb [$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_at(input int when, input int id, input logic [7:0] d,
                          input logic [7:0] r, input logic [7:0] f,
                          input logic [7:0] p, input logic q);
        exp_t e;
        int   i;
        e.cyc = when; e.id = id; e.din = d; e.rise = r; e.fall = f; e.pend = p; e.irq = q;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > when) i--;
        sb.insert(i, e);
    endtask

    // Compare every expectation stamped for this cycle; late ones are errors.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc != cyc || din_o !== mon_e.din || rise_o !== mon_e.rise ||
                fall_o !== mon_e.fall || pend_o !== mon_e.pend || irq_o !== mon_e.irq) begin
                errors++;
                $display("FAIL chk%0d cyc=%0d (due %0d): got din=%h rise=%h fall=%h pend=%h irq=%b, expected din=%h rise=%h fall=%h pend=%h irq=%b",
                         mon_e.id, cyc, mon_e.cyc, din_o, rise_o, fall_o, pend_o, irq_o,
                         mon_e.din, mon_e.rise, mon_e.fall, mon_e.pend, mon_e.irq);
            end
        end
    end

    initial begin
        int c;
        int r;
        //          en    lim    pad    clr   w every  din    rise   fall   pend  irq
        vecs[0]  = '{1'b1, 8'd3, 8'h01, 8'h00, 5, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 8'd3, 8'h01, 8'h00, 1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1};
        vecs[2]  = '{1'b1, 8'd3, 8'h01, 8'h00, 1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
        vecs[3]  = '{1'b1, 8'd3, 8'h01, 8'h01, 1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 8'd3, 8'h00, 8'h00, 2, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 8'd3, 8'h00, 8'h00, 1, 1'b0, 8'h00, 8'h00, 8'h01, 8'h01, 1'b1};
        vecs[6]  = '{1'b0, 8'd3, 8'h00, 8'h01, 1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 8'd3, 8'hA5, 8'h00, 2, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 8'd3, 8'hA5, 8'h00, 1, 1'b0, 8'hA5, 8'hA5, 8'h00, 8'hA5, 1'b1};
        vecs[9]  = '{1'b0, 8'd3, 8'hA5, 8'hFF, 1, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 8'd3, 8'h00, 8'h00, 5, 1'b1, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 8'd3, 8'h00, 8'h00, 1, 1'b0, 8'h00, 8'h00, 8'hA5, 8'hA5, 1'b1};
        vecs[12] = '{1'b1, 8'd3, 8'h00, 8'hFF, 1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[13] = '{1'b1, 8'd3, 8'h02, 8'h00, 3, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[14] = '{1'b1, 8'd3, 8'h00, 8'h00, 8, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[15] = '{1'b1, 8'd3, 8'h02, 8'h00, 4, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[16] = '{1'b1, 8'd3, 8'h00, 8'h00, 1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[17] = '{1'b1, 8'd3, 8'h00, 8'h00, 1, 1'b0, 8'h02, 8'h02, 8'h00, 8'h02, 1'b1};
        vecs[18] = '{1'b1, 8'd3, 8'h00, 8'h00, 3, 1'b1, 8'h02, 8'h00, 8'h00, 8'h02, 1'b1};
        vecs[19] = '{1'b1, 8'd3, 8'h00, 8'h00, 1, 1'b0, 8'h00, 8'h00, 8'h02, 8'h02, 1'b1};
        vecs[20] = '{1'b1, 8'd3, 8'h00, 8'h02, 1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[21] = '{1'b1, 8'd3, 8'h01, 8'h00, 5, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[22] = '{1'b1, 8'd3, 8'h01, 8'h00, 1, 1'b0, 8'h01, 8'h01, 8'h00, 8'h01, 1'b1};
        vecs[23] = '{1'b1, 8'd3, 8'h01, 8'h00, 2, 1'b1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
        vecs[24] = '{1'b1, 8'd3, 8'h02, 8'h00, 5, 1'b1, 8'h01, 8'h00, 8'h00, 8'h01, 1'b1};
        vecs[25] = '{1'b1, 8'd3, 8'h02, 8'h03, 1, 1'b0, 8'h02, 8'h02, 8'h01, 8'h03, 1'b1};
        vecs[26] = '{1'b1, 8'd3, 8'h02, 8'h03, 1, 1'b0, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[27] = '{1'b1, 8'd3, 8'h00, 8'h00, 5, 1'b1, 8'h02, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[28] = '{1'b1, 8'd3, 8'h00, 8'h00, 1, 1'b0, 8'h00, 8'h00, 8'h02, 8'h02, 1'b1};
        vecs[29] = '{1'b1, 8'd3, 8'h00, 8'hFF, 1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[30] = '{1'b1, 8'd0, 8'h04, 8'h00, 2, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[31] = '{1'b1, 8'd0, 8'h04, 8'h00, 1, 1'b0, 8'h04, 8'h04, 8'h00, 8'h04, 1'b1};
        vecs[32] = '{1'b1, 8'd0, 8'h00, 8'h04, 1, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[33] = '{1'b1, 8'd0, 8'h00, 8'h00, 1, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[34] = '{1'b1, 8'd0, 8'h00, 8'h00, 1, 1'b0, 8'h00, 8'h00, 8'h04, 8'h04, 1'b1};

        rst = 1'b1; cfg_en = 1'b1; cfg_limit = 8'd3; pad_i = 8'h00; evt_clr_i = 8'h00;
        tick(3);
        rst = 1'b0;
        exp_at(cyc, 900, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

        // Directed vectors: inputs held for w edges, expectation at the last
        // edge (or at every edge of the window when 'every' is set).
        for (int k = 0; k < NV; k++) begin
            cfg_en = vecs[k].en; cfg_limit = vecs[k].lim;
            pad_i = vecs[k].pad; evt_clr_i = vecs[k].clr;
            if (vecs[k].every) begin
                for (int d = 1; d <= vecs[k].w; d++)
                    exp_at(cyc + d, k, vecs[k].din, vecs[k].rise, vecs[k].fall, vecs[k].pend, vecs[k].irq);
            end else begin
                exp_at(cyc + vecs[k].w, k, vecs[k].din, vecs[k].rise, vecs[k].fall, vecs[k].pend, vecs[k].irq);
            end
            tick(vecs[k].w);
        end
        evt_clr_i = 8'h00;

        // Reset in the middle of a long count: everything clears and the
        // full 2+200+1 latency restarts from release.
        cfg_limit = 8'd200; pad_i = 8'h04;
        c = cyc;
        for (int d = 1; d <= 100; d++) exp_at(c + d, 100, 8'h00, 8'h00, 8'h00, 8'h04, 1'b1);
        tick(100);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        r = cyc;
        exp_at(r, 101, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int d = 1; d <= 202; d++) exp_at(r + d, 102, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        exp_at(r + 203, 103, 8'h04, 8'h04, 8'h00, 8'h04, 1'b1);
        tick(203);

        // Return to all-zero through bypass, then clear.
        cfg_en = 1'b0; pad_i = 8'h00;
        c = cyc;
        exp_at(c + 1, 110, 8'h04, 8'h00, 8'h00, 8'h04, 1'b1);
        exp_at(c + 2, 110, 8'h04, 8'h00, 8'h00, 8'h04, 1'b1);
        exp_at(c + 3, 111, 8'h00, 8'h00, 8'h04, 8'h04, 1'b1);
        tick(3);
        evt_clr_i = 8'hFF;
        exp_at(cyc + 1, 112, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick(1);
        evt_clr_i = 8'h00;

        // Lower the limit below a running count of 50: update on next edge.
        cfg_en = 1'b1; cfg_limit = 8'd200; pad_i = 8'h08;
        c = cyc;
        for (int d = 1; d <= 52; d++) exp_at(c + d, 120, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        tick(52);
        cfg_limit = 8'd10;
        exp_at(c + 53, 121, 8'h08, 8'h08, 8'h00, 8'h08, 1'b1);
        exp_at(c + 54, 122, 8'h08, 8'h00, 8'h00, 8'h08, 1'b1);
        tick(2);

        // Drain the scoreboard within a bounded number of cycles.
        for (int t = 0; t < 20 && sb.size() > 0; t++) tick(1);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        tick(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
